// File: rtl/gray_seq_pkg.sv
// gray_seq_pkg: opcodes, FSM states and direction encoding for the Gray counter sequencer
package gray_seq_pkg;
  localparam logic [2:0] OP_STOP    = 3'd0;
  localparam logic [2:0] OP_RUN     = 3'd1;
  localparam logic [2:0] OP_STEP    = 3'd2;
  localparam logic [2:0] OP_LOAD    = 3'd3;
  localparam logic [2:0] OP_CLEAR   = 3'd4;
  localparam logic [2:0] OP_SET_DIR = 3'd5;
  localparam logic [2:0] OP_RUN_TO  = 3'd6;
  localparam logic [2:0] OP_RSVD    = 3'd7;
  localparam logic DIR_UP   = 1'b0;
  localparam logic DIR_DOWN = 1'b1;
  typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_RUN_TO, ST_STEP_WAIT} state_t;
endpackage

// File: rtl/gray_counter_sequencer_us_tick_gen.sv
// us_tick_gen: divides clk by CLOCK_MHZ into a one-cycle 1 us strobe, re-phased by restart
module us_tick_gen #(
  parameter int CLOCK_MHZ      = 16,
  parameter int CLOCK_MHZ_BITS = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic enable,
  input  logic restart,
  output logic tick
);
  localparam logic [CLOCK_MHZ_BITS-1:0] LAST = CLOCK_MHZ_BITS'(CLOCK_MHZ - 1);
  logic [CLOCK_MHZ_BITS-1:0] cnt;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) cnt <= '0;
    else cnt <= (!enable || restart || cnt == LAST) ? '0 : cnt + 1'b1;
  assign tick = enable & ~restart & (cnt == LAST);
endmodule

// File: rtl/gray_counter_sequencer.sv
// gray_counter_sequencer: command-sequenced binary counter with registered Gray-coded pin output
module gray_counter_sequencer
  import gray_seq_pkg::*;
#(
  parameter int CLOCK_MHZ      = 16,
  parameter int CLOCK_MHZ_BITS = 4,
  parameter int BITS           = 8
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            cmd_valid,
  output logic            cmd_ready,
  input  logic [2:0]      cmd_op,
  input  logic [BITS-1:0] cmd_data,
  output logic [BITS-1:0] gray_out,
  output logic [BITS-1:0] bin_out,
  output logic            running,
  output logic            done,
  output logic            tick
);
  state_t st, st_n;
  logic dir, dir_n, rdy_q, restart_q, restart_n, done_n, acc, kill, hit, adv;
  logic [BITS-1:0] tgt, tgt_n, bin_n, stepped;
  us_tick_gen #(.CLOCK_MHZ(CLOCK_MHZ), .CLOCK_MHZ_BITS(CLOCK_MHZ_BITS)) u_tick (
    .clk(clk),
    .rst_n(rst_n),
    .enable(st != ST_IDLE),
    .restart(restart_q),
    .tick(tick)
  );
  assign cmd_ready = rdy_q & (st != ST_STEP_WAIT);
  assign running = (st == ST_RUN) | (st == ST_RUN_TO);
  assign acc = cmd_valid & cmd_ready;
  // LOAD/CLEAR/STOP override a coincident advance; reaching target without a tick ends RUN_TO in place
  assign kill = acc & ((cmd_op == OP_STOP) | (cmd_op == OP_LOAD) | (cmd_op == OP_CLEAR));
  assign hit = ~acc & (st == ST_RUN_TO) & (bin_out == tgt);
  assign adv = tick & ~kill & ~hit;
  assign stepped = (dir == DIR_DOWN) ? bin_out - 1'b1 : bin_out + 1'b1;
  assign bin_n = (acc & (cmd_op == OP_LOAD)) ? cmd_data :
                 (acc & (cmd_op == OP_CLEAR)) ? '0 :
                 adv ? stepped : bin_out;
  always_comb begin
    st_n = st;
    dir_n = dir;
    tgt_n = tgt;
    restart_n = 1'b0;
    done_n = 1'b0;
    if (acc) begin
      case (cmd_op)
        OP_STOP: st_n = ST_IDLE;
        OP_RUN: begin
          st_n = ST_RUN;
          restart_n = 1'b1;
        end
        OP_STEP: begin
          st_n = ST_STEP_WAIT;
          restart_n = 1'b1;
        end
        OP_SET_DIR: dir_n = cmd_data[0];
        OP_RUN_TO: begin
          st_n = ST_RUN_TO;
          tgt_n = cmd_data;
          restart_n = 1'b1;
        end
        default: ;
      endcase
    end else if (st == ST_STEP_WAIT && tick) begin
      st_n = ST_IDLE;
    end else if (hit || (st == ST_RUN_TO && tick && stepped == tgt)) begin
      st_n = ST_IDLE;
      done_n = 1'b1;
    end
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      st <= ST_IDLE;
      bin_out <= '0;
      gray_out <= '0;
      dir <= DIR_UP;
      tgt <= '0;
      rdy_q <= 1'b0;
      restart_q <= 1'b0;
      done <= 1'b0;
    end else begin
      st <= st_n;
      bin_out <= bin_n;
      gray_out <= bin_n ^ (bin_n >> 1);
      dir <= dir_n;
      tgt <= tgt_n;
      rdy_q <= 1'b1;
      restart_q <= restart_n;
      done <= done_n;
    end
endmodule

// File: tb/tb_gray_counter_sequencer.sv
// tb_gray_counter_sequencer: table vectors plus scoreboarded multi-cycle sequences
module tb_gray_counter_sequencer;
  import gray_seq_pkg::*;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic cmd_valid = 1'b0;
  logic cmd_ready;
  logic [2:0] cmd_op = 3'd0;
  logic [7:0] cmd_data = 8'd0;
  logic [7:0] gray_out, bin_out;
  logic running, done, tick;
  int total = 0;
  int bad = 0;

  gray_counter_sequencer #(.CLOCK_MHZ(16), .CLOCK_MHZ_BITS(4), .BITS(8)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .cmd_valid(cmd_valid),
    .cmd_ready(cmd_ready),
    .cmd_op(cmd_op),
    .cmd_data(cmd_data),
    .gray_out(gray_out),
    .bin_out(bin_out),
    .running(running),
    .done(done),
    .tick(tick)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] bin;
    logic [7:0] gray;
    bit         adv;
  } exp_t;
  exp_t exp_q[$];

  typedef struct {
    logic [2:0] op;
    logic [7:0] data;
    logic [7:0] bin;
    logic [7:0] gray;
  } vec_t;

  bit mon_en = 1'b0;
  logic [7:0] prev_bin = 8'd0;
  logic [7:0] prev_gray = 8'd0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, req, $time);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic push(input logic [7:0] b, input logic [7:0] g, input bit a);
    exp_t e;
    e.bin = b;
    e.gray = g;
    e.adv = a;
    exp_q.push_back(e);
  endtask

  // returns 1 ns after the accepting edge
  task automatic send(input logic [2:0] op, input logic [7:0] d);
    int n = 0;
    cmd_op = op;
    cmd_data = d;
    cmd_valid = 1'b1;
    while (!cmd_ready && n < 50) begin
      cyc(1);
      n++;
    end
    if (!cmd_ready) chk("ready_timeout", {31'd0, cmd_ready}, 32'd1);
    cyc(1);
    cmd_valid = 1'b0;
  endtask

  always begin
    exp_t e;
    @(posedge clk);
    #1;
    if (mon_en && bin_out !== prev_bin) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_change", {24'd0, bin_out}, {24'd0, prev_bin});
      end else begin
        e = exp_q.pop_front();
        chk("sb_bin", {24'd0, bin_out}, {24'd0, e.bin});
        chk("sb_gray", {24'd0, gray_out}, {24'd0, e.gray});
        if (e.adv) chk("gray_hamming", $countones(gray_out ^ prev_gray), 32'd1);
      end
    end
    prev_bin = bin_out;
    prev_gray = gray_out;
  end

  initial begin
    vec_t vt[8];
    logic [7:0] last;
    int cnt, at;
    vt[0] = '{OP_LOAD,    8'h5A, 8'h5A, 8'h77};
    vt[1] = '{OP_CLEAR,   8'h33, 8'h00, 8'h00};
    vt[2] = '{OP_LOAD,    8'hFF, 8'hFF, 8'h80};
    vt[3] = '{OP_RSVD,    8'h12, 8'hFF, 8'h80};
    vt[4] = '{OP_SET_DIR, 8'h01, 8'hFF, 8'h80};
    vt[5] = '{OP_STOP,    8'h00, 8'hFF, 8'h80};
    vt[6] = '{OP_SET_DIR, 8'h00, 8'hFF, 8'h80};
    vt[7] = '{OP_LOAD,    8'h10, 8'h10, 8'h18};

    cmd_valid = 1'b1;
    cmd_op = OP_RUN;
    cyc(4);
    chk("rst_bin", {24'd0, bin_out}, 32'h00);
    chk("rst_gray", {24'd0, gray_out}, 32'h00);
    chk("rst_ready", {31'd0, cmd_ready}, 32'd0);
    chk("rst_running", {31'd0, running}, 32'd0);
    chk("rst_done_tick", {30'd0, done, tick}, 32'd0);
    cmd_valid = 1'b0;
    rst_n = 1'b1;
    #1;
    chk("ready_before_edge", {31'd0, cmd_ready}, 32'd0);
    cyc(1);
    chk("ready_after_edge", {31'd0, cmd_ready}, 32'd1);

    mon_en = 1'b1;
    last = 8'h00;
    for (int i = 0; i < 8; i++) begin
      if (vt[i].bin != last) push(vt[i].bin, vt[i].gray, 1'b0);
      last = vt[i].bin;
      send(vt[i].op, vt[i].data);
      cyc(1);
      chk("vec_bin", {24'd0, bin_out}, {24'd0, vt[i].bin});
      chk("vec_gray", {24'd0, gray_out}, {24'd0, vt[i].gray});
      chk("vec_idle", {31'd0, running}, 32'd0);
    end

    push(8'hFE, 8'h81, 1'b0);
    send(OP_LOAD, 8'hFE);
    push(8'hFF, 8'h80, 1'b1);
    push(8'h00, 8'h00, 1'b1);
    send(OP_RUN, 8'h00);
    chk("run_running", {31'd0, running}, 32'd1);
    cyc(16);
    chk("run_n16", {24'd0, bin_out}, 32'hFE);
    cyc(1);
    chk("run_n17", {24'd0, bin_out}, 32'hFF);
    cyc(15);
    chk("run_n32", {24'd0, bin_out}, 32'hFF);
    cyc(1);
    chk("run_wrap_n33", {24'd0, bin_out}, 32'h00);
    cyc(15);
    chk("tick_at_load", {31'd0, tick}, 32'd1);
    push(8'h40, 8'h60, 1'b0);
    push(8'h41, 8'h61, 1'b1);
    send(OP_LOAD, 8'h40);
    chk("load_wins", {24'd0, bin_out}, 32'h40);
    cyc(15);
    chk("after_load_15", {24'd0, bin_out}, 32'h40);
    cyc(1);
    chk("after_load_16", {24'd0, bin_out}, 32'h41);
    send(OP_STOP, 8'h00);
    chk("stop_running", {31'd0, running}, 32'd0);
    cyc(40);
    chk("stop_held", {24'd0, bin_out}, 32'h41);

    push(8'h00, 8'h00, 1'b0);
    send(OP_CLEAR, 8'h00);
    send(OP_SET_DIR, 8'h01);
    push(8'hFF, 8'h80, 1'b1);
    push(8'hFE, 8'h81, 1'b1);
    push(8'hFD, 8'h83, 1'b1);
    send(OP_RUN_TO, 8'hFD);
    cnt = 0;
    at = 0;
    for (int k = 1; k <= 60; k++) begin
      cyc(1);
      if (done) begin
        cnt++;
        at = k;
        chk("done_bin", {24'd0, bin_out}, 32'hFD);
        chk("done_running", {31'd0, running}, 32'd0);
      end
    end
    chk("runto_done_count", cnt, 32'd1);
    chk("runto_done_cycle", at, 32'd49);
    chk("runto_final", {24'd0, bin_out}, 32'hFD);

    push(8'h10, 8'h18, 1'b0);
    send(OP_LOAD, 8'h10);
    send(OP_SET_DIR, 8'h00);
    push(8'h11, 8'h19, 1'b1);
    send(OP_STEP, 8'h00);
    cnt = 0;
    for (int k = 0; k <= 16; k++) begin
      if (k > 0) cyc(1);
      if (cmd_ready !== 1'b0 || bin_out !== 8'h10) cnt++;
    end
    chk("step_wait_hold", cnt, 32'd0);
    cyc(1);
    chk("step_n17", {24'd0, bin_out}, 32'h11);
    chk("step_ready_back", {31'd0, cmd_ready}, 32'd1);
    cnt = 0;
    for (int k = 0; k < 40; k++) begin
      cyc(1);
      if (tick || done) cnt++;
    end
    chk("step_no_more", cnt, 32'd0);
    chk("step_final", {24'd0, bin_out}, 32'h11);
    chk("queue_empty", exp_q.size(), 32'd0);

    mon_en = 1'b0;
    send(OP_RUN_TO, 8'h20);
    cyc(20);
    chk("pre_reset_bin", {24'd0, bin_out}, 32'h12);
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    chk("async_bin", {24'd0, bin_out}, 32'h00);
    chk("async_gray", {24'd0, gray_out}, 32'h00);
    chk("async_flags", {28'd0, running, done, tick, cmd_ready}, 32'd0);
    cnt = 0;
    for (int k = 0; k < 3; k++) begin
      cyc(1);
      if (done) cnt++;
    end
    chk("reset_no_done", cnt, 32'd0);
    rst_n = 1'b1;
    cyc(1);
    chk("reset_ready", {31'd0, cmd_ready}, 32'd1);

    send(OP_RUN_TO, 8'h00);
    chk("eq_done_early", {31'd0, done}, 32'd0);
    cyc(1);
    chk("eq_done", {31'd0, done}, 32'd1);
    chk("eq_running", {31'd0, running}, 32'd0);
    cyc(1);
    chk("eq_done_drop", {31'd0, done}, 32'd0);
    cnt = 0;
    for (int k = 0; k < 30; k++) begin
      cyc(1);
      if (done || bin_out !== 8'h00) cnt++;
    end
    chk("eq_no_advance", cnt, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
